mips_multicycle_controller: RTL and testbench
=============================================

MIPS_MULTICYCLE_CONTROLLER -- requirements
Module: mips_multicycle_controller

Interface
REQ-001 Parameter WAIT_LIMIT, default 16, is the maximum consecutive cycles a memory state waits for mem_ready before the block enters ERROR.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset; asynchronous and active-low.
REQ-004 opcode  input  6  instruction register bits [31:26].
REQ-005 funct  input  6  instruction register bits [5:0].
REQ-006 zero  input  1  ALU zero flag from the datapath.
REQ-007 mem_ready  input  1  shared memory has completed the current read or write.
REQ-008 pc_write  output  1  PC load enable (unconditional, or branch-taken).
REQ-009 iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 mem_read, mem_write  output  1 each  memory request strobes, held until mem_ready.
REQ-011 ir_write  output  1  instruction register load.
REQ-012 reg_write  output  1  register file write enable.
REQ-013 reg_dst  output  2  write register select: 00 = rt, 01 = rd, 10 = r31.
REQ-014 mem_to_reg  output  2  write data select: 00 = ALUOut, 01 = MDR, 10 = PC.
REQ-015 alu_src_a  output  1  ALU A select: 0 = PC, 1 = rs.
REQ-016 alu_src_b  output  2  ALU B select: 00 = rt, 01 = const 4, 10 = sext, 11 = sext<<2.
REQ-017 alu_op  output  3  ALU operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-018 pc_src  output  2  PC source: 00 = ALU, 01 = ALUOut, 10 = {PC[31:28], imm26, 00}, 11 = rs.
REQ-019 err  output  1  sticky error flag (illegal instruction or memory timeout).

Function
REQ-020 The FSM states SHALL be: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JAL, JR, ERROR.
REQ-021 Outputs SHALL be decoded combinationally from the state, plus zero and mem_ready where specified below; every output not listed for a state SHALL be 0.
REQ-022 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00; ir_write = pc_write = mem_ready; the FSM SHALL stay in FETCH while mem_ready=0 and go to DECODE otherwise.
REQ-023 DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD.
- Next state by opcode: 000000 -> R_EXEC, or JR if funct=001000.
- 100011/101011 -> MEM_ADDR; 001000/001010 -> I_EXEC; 000100 -> BRANCH; 000010 -> JUMP; 000011 -> JAL.
- Any other opcode, or an unsupported R-type funct -> ERROR.
REQ-024 R_EXEC: alu_src_a=1, alu_src_b=00; funct mapping 100000 -> ADD, 100010 -> SUB, 100100 -> AND, 100101 -> OR, 101010 -> SLT; next state R_WB.
REQ-025 R_WB: reg_write=1, reg_dst=01, mem_to_reg=00; next state FETCH.
REQ-026 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD; next state MEM_RD for lw, MEM_WR for sw.
REQ-027 MEM_RD: mem_read=1, iord=1; waits for mem_ready, then goes to MEM_WB.
MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01; next state FETCH.
REQ-028 MEM_WR: mem_write=1, iord=1; waits for mem_ready, then goes to FETCH.
REQ-029 I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=ADD (addi) or SLT (slti); next state I_WB.
I_WB: reg_write=1, reg_dst=00, mem_to_reg=00; next state FETCH.
REQ-030 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01, pc_write=zero; next state FETCH.
REQ-031 JUMP: pc_src=10, pc_write=1 -> FETCH.
JAL: additionally reg_write=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4) -> FETCH.
JR: pc_src=11, pc_write=1 -> FETCH.
REQ-032 A wait counter SHALL clear on entry to FETCH, MEM_RD or MEM_WR and increment each cycle mem_ready=0; when it reaches WAIT_LIMIT with mem_ready still 0, the FSM SHALL go to ERROR.
REQ-033 mem_ready sampled 1 in the same cycle the counter reaches WAIT_LIMIT SHALL complete the access normally.
REQ-034 ERROR SHALL drive all strobes to 0 and err=1, and SHALL be left only by reset.
REQ-035 Zero-wait latencies SHALL be: beq/j/jal/jr 3 cycles, R-type/addi/slti/sw 4 cycles, lw 5 cycles.

Reset
REQ-036 While rst=0 the state SHALL be FETCH with all outputs forced to 0, err=0 and wait counter=0.
REQ-037 Reset asserted mid-instruction SHALL abort immediately with no pending write strobes; the first cycle after release SHALL begin FETCH.

Structure
REQ-038 Opcode, funct and alu_op encodings, the state enum, and mux-select constants SHALL live in a shared package mips_ctrl_pkg.
REQ-039 The funct-to-alu_op mapping SHALL be a sub-module, mips_alu_decoder.

Verification
REQ-040 lw, mem_ready tied 1: state sequence FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB; reg_write=1 only in cycle 5 with mem_to_reg=01.
REQ-041 beq with zero=1, then zero=0: pc_write=1 and 0 respectively in cycle 3, pc_src=01 in both cases.
REQ-042 jal: cycle 3 has pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10.
REQ-043 sw with mem_ready low for 5 cycles (WAIT_LIMIT=16): mem_write held 6 cycles, then FETCH, err=0; held low for 16 cycles -> ERROR, err=1.
REQ-044 opcode 111111, then funct 000111 with opcode 0: ERROR after DECODE with err=1 and no reg_write; rst pulse low returns to FETCH with err=0.
REQ-045 rst asserted during R_WB: reg_write drops asynchronously; after release, FETCH with mem_read=1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: instruction fields,
// ALU operations, datapath mux selects, FSM states and the control bundle.
package mips_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // ALU operations
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Datapath mux selects
    localparam logic [1:0] REGDST_RT   = 2'b00;
    localparam logic [1:0] REGDST_RD   = 2'b01;
    localparam logic [1:0] REGDST_RA   = 2'b10;
    localparam logic [1:0] WD_ALUOUT   = 2'b00;
    localparam logic [1:0] WD_MDR      = 2'b01;
    localparam logic [1:0] WD_PC       = 2'b10;
    localparam logic       SRCA_PC     = 1'b0;
    localparam logic       SRCA_RS     = 1'b1;
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_SEXT   = 2'b10;
    localparam logic [1:0] SRCB_SEXT2  = 2'b11;
    localparam logic [1:0] PCSRC_ALU   = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT= 2'b01;
    localparam logic [1:0] PCSRC_JUMP  = 2'b10;
    localparam logic [1:0] PCSRC_RS    = 2'b11;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB,
        I_EXEC, I_WB, BRANCH, JUMP, JAL, JR, ERROR
    } state_t;

    // Every controller output in one bundle so idle/reset values are one assignment
    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       err;
    } ctrl_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps an R-type funct field to its ALU operation; valid flags supported functs.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       valid
);

    // Funct lookup; unsupported codes report invalid with a harmless ADD
    always_comb begin
        alu_op = ALU_ADD;
        valid  = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: begin
                alu_op = ALU_ADD;
                valid  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM with a memory wait-timeout watchdog.
// Outputs are decoded from the state (plus zero/mem_ready) and are forced
// to zero while reset is held, so an in-flight write strobe drops at once.
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_src,
    output logic       err
);

    localparam int            CW       = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_M1 = CW'(WAIT_LIMIT - 1);

    state_t        state_r;
    state_t        state_next_s;
    logic [CW-1:0] wait_cnt_r;
    logic          waiting_s;
    logic          timeout_s;
    logic [2:0]    rtype_alu_op_s;
    logic          rtype_valid_s;
    ctrl_t         ctrl_s;
    ctrl_t         ctrl_out_s;

    mips_alu_decoder u_alu_decoder (
        .funct  (funct),
        .alu_op (rtype_alu_op_s),
        .valid  (rtype_valid_s)
    );

    // States that hold a memory request open until mem_ready
    assign waiting_s = (state_r == FETCH) || (state_r == MEM_RD) || (state_r == MEM_WR);
    // This low-ready cycle would be the WAIT_LIMIT-th consecutive one
    assign timeout_s = (wait_cnt_r == LIMIT_M1);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Wait counter: restarts on every state change, counts low-ready cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= CW'(0);
        end else if (state_next_s != state_r) begin
            wait_cnt_r <= CW'(0);
        end else if (waiting_s && !mem_ready) begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Next-state and per-state output decode
    always_comb begin
        state_next_s = state_r;
        ctrl_s       = '0;
        case (state_r)
            FETCH: begin
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.alu_src_a = SRCA_PC;
                ctrl_s.alu_src_b = SRCB_FOUR;
                ctrl_s.alu_op    = ALU_ADD;
                ctrl_s.pc_src    = PCSRC_ALU;
                ctrl_s.ir_write  = mem_ready;
                ctrl_s.pc_write  = mem_ready;
                if (mem_ready)      state_next_s = DECODE;
                else if (timeout_s) state_next_s = ERROR;
                else                state_next_s = FETCH;
            end
            DECODE: begin
                ctrl_s.alu_src_a = SRCA_PC;
                ctrl_s.alu_src_b = SRCB_SEXT2;
                ctrl_s.alu_op    = ALU_ADD;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_JR)     state_next_s = JR;
                        else if (rtype_valid_s) state_next_s = R_EXEC;
                        else                    state_next_s = ERROR;
                    end
                    OP_LW, OP_SW:     state_next_s = MEM_ADDR;
                    OP_ADDI, OP_SLTI: state_next_s = I_EXEC;
                    OP_BEQ:           state_next_s = BRANCH;
                    OP_J:             state_next_s = JUMP;
                    OP_JAL:           state_next_s = JAL;
                    default:          state_next_s = ERROR;
                endcase
            end
            R_EXEC: begin
                ctrl_s.alu_src_a = SRCA_RS;
                ctrl_s.alu_src_b = SRCB_RT;
                ctrl_s.alu_op    = rtype_alu_op_s;
                state_next_s     = R_WB;
            end
            R_WB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.reg_dst    = REGDST_RD;
                ctrl_s.mem_to_reg = WD_ALUOUT;
                state_next_s      = FETCH;
            end
            MEM_ADDR: begin
                ctrl_s.alu_src_a = SRCA_RS;
                ctrl_s.alu_src_b = SRCB_SEXT;
                ctrl_s.alu_op    = ALU_ADD;
                if (opcode == OP_LW) state_next_s = MEM_RD;
                else                 state_next_s = MEM_WR;
            end
            MEM_RD: begin
                ctrl_s.mem_read = 1'b1;
                ctrl_s.iord     = 1'b1;
                if (mem_ready)      state_next_s = MEM_WB;
                else if (timeout_s) state_next_s = ERROR;
                else                state_next_s = MEM_RD;
            end
            MEM_WB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.reg_dst    = REGDST_RT;
                ctrl_s.mem_to_reg = WD_MDR;
                state_next_s      = FETCH;
            end
            MEM_WR: begin
                ctrl_s.mem_write = 1'b1;
                ctrl_s.iord      = 1'b1;
                if (mem_ready)      state_next_s = FETCH;
                else if (timeout_s) state_next_s = ERROR;
                else                state_next_s = MEM_WR;
            end
            I_EXEC: begin
                ctrl_s.alu_src_a = SRCA_RS;
                ctrl_s.alu_src_b = SRCB_SEXT;
                ctrl_s.alu_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                state_next_s     = I_WB;
            end
            I_WB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.reg_dst    = REGDST_RT;
                ctrl_s.mem_to_reg = WD_ALUOUT;
                state_next_s      = FETCH;
            end
            BRANCH: begin
                ctrl_s.alu_src_a = SRCA_RS;
                ctrl_s.alu_src_b = SRCB_RT;
                ctrl_s.alu_op    = ALU_SUB;
                ctrl_s.pc_src    = PCSRC_ALUOUT;
                ctrl_s.pc_write  = zero;
                state_next_s     = FETCH;
            end
            JUMP: begin
                ctrl_s.pc_src   = PCSRC_JUMP;
                ctrl_s.pc_write = 1'b1;
                state_next_s    = FETCH;
            end
            JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value
                ctrl_s.pc_src     = PCSRC_JUMP;
                ctrl_s.pc_write   = 1'b1;
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.reg_dst    = REGDST_RA;
                ctrl_s.mem_to_reg = WD_PC;
                state_next_s      = FETCH;
            end
            JR: begin
                ctrl_s.pc_src   = PCSRC_RS;
                ctrl_s.pc_write = 1'b1;
                state_next_s    = FETCH;
            end
            ERROR: begin
                ctrl_s.err   = 1'b1;
                state_next_s = ERROR;
            end
            default: begin
                ctrl_s.err   = 1'b1;
                state_next_s = ERROR;
            end
        endcase
    end

    // Reset gating: all outputs silent while rst is held low
    always_comb begin
        if (!rst) begin
            ctrl_out_s = '0;
        end else begin
            ctrl_out_s = ctrl_s;
        end
    end

    assign pc_write   = ctrl_out_s.pc_write;
    assign iord       = ctrl_out_s.iord;
    assign mem_read   = ctrl_out_s.mem_read;
    assign mem_write  = ctrl_out_s.mem_write;
    assign ir_write   = ctrl_out_s.ir_write;
    assign reg_write  = ctrl_out_s.reg_write;
    assign reg_dst    = ctrl_out_s.reg_dst;
    assign mem_to_reg = ctrl_out_s.mem_to_reg;
    assign alu_src_a  = ctrl_out_s.alu_src_a;
    assign alu_src_b  = ctrl_out_s.alu_src_b;
    assign alu_op     = ctrl_out_s.alu_op;
    assign pc_src     = ctrl_out_s.pc_src;
    assign err        = ctrl_out_s.err;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Self-checking bench: an instruction-level model expands each instruction
// into its expected per-cycle output vectors; a negedge process compares.
module tb_mips_multicycle_controller;

    localparam int WL = 16;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
    logic       alu_src_a, err;
    logic [2:0] alu_op;

    vec_t  act;
    vec_t  cur_exp;
    vec_t  exp_q[$];
    logic  rdy_q[$];
    logic  cmp_en = 1'b0;
    string cur_name = "reset";
    int    vectors = 0;
    int    miscompares = 0;
    logic [7:0]  rw_hist = 8'd0;
    logic [7:0]  pw_hist = 8'd0;
    logic [15:0] mw_hist = 16'd0;

    mips_multicycle_controller #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .err(err)
    );

    assign act = {pc_write, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, err};

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        vectors = vectors + 1;
        if (a !== e) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    // Compare process: checks the current expected vector and records strobe history
    always @(negedge clk) begin
        if (cmp_en) chk(cur_name, 32'(act), 32'(cur_exp));
        rw_hist <= {rw_hist[6:0], reg_write};
        pw_hist <= {pw_hist[6:0], pc_write};
        mw_hist <= {mw_hist[14:0], mem_write};
    end

    // ---------------- behavioural model ----------------
    task automatic push(input vec_t v, input logic r);
        exp_q.push_back(v);
        rdy_q.push_back(r);
    endtask

    task automatic push_err();
        vec_t v;
        v = '0;
        v.err = 1'b1;
        for (int i = 0; i < 3; i++) push(v, 1'($urandom));
    endtask

    // Memory access: 'waits' low-ready cycles; WL of them is a timeout
    task automatic access(input vec_t base, input logic is_fetch, input int waits,
                          output logic timed_out);
        vec_t v;
        for (int k = 0; k < waits && k < WL; k++) push(base, 1'b0);
        if (waits >= WL) begin
            timed_out = 1'b1;
        end else begin
            v = base;
            if (is_fetch) begin
                v.ir_write = 1'b1;
                v.pc_write = 1'b1;
            end
            push(v, 1'b1);
            timed_out = 1'b0;
        end
    endtask

    function automatic logic [3:0] rmap(input logic [5:0] fn);
        case (fn) // {known, alu_op}
            6'b100000: return 4'b1010;
            6'b100010: return 4'b1110;
            6'b100100: return 4'b1000;
            6'b100101: return 4'b1001;
            6'b101010: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int fw, input int mw);
        vec_t v;
        logic to;
        logic [3:0] rm;
        v = '0; v.mem_read = 1'b1; v.alu_src_b = 2'b01; v.alu_op = 3'b010;
        access(v, 1'b1, fw, to);
        if (to) begin push_err(); return; end
        v = '0; v.alu_src_b = 2'b11; v.alu_op = 3'b010;
        push(v, 1'($urandom));
        case (op)
            6'b000000: begin
                rm = rmap(fn);
                if (fn == 6'b001000) begin
                    v = '0; v.pc_src = 2'b11; v.pc_write = 1'b1; push(v, 1'b1);
                end else if (rm[3]) begin
                    v = '0; v.alu_src_a = 1'b1; v.alu_op = rm[2:0]; push(v, 1'b0);
                    v = '0; v.reg_write = 1'b1; v.reg_dst = 2'b01; push(v, 1'b1);
                end else begin
                    push_err();
                end
            end
            6'b100011, 6'b101011: begin
                v = '0; v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.alu_op = 3'b010;
                push(v, 1'b1);
                v = '0; v.iord = 1'b1;
                if (op == 6'b100011) v.mem_read = 1'b1; else v.mem_write = 1'b1;
                access(v, 1'b0, mw, to);
                if (to) push_err();
                else if (op == 6'b100011) begin
                    v = '0; v.reg_write = 1'b1; v.mem_to_reg = 2'b01; push(v, 1'b0);
                end
            end
            6'b001000, 6'b001010: begin
                v = '0; v.alu_src_a = 1'b1; v.alu_src_b = 2'b10;
                v.alu_op = (op == 6'b001010) ? 3'b111 : 3'b010;
                push(v, 1'b1);
                v = '0; v.reg_write = 1'b1; push(v, 1'b0);
            end
            6'b000100: begin
                v = '0; v.alu_src_a = 1'b1; v.alu_op = 3'b110; v.pc_src = 2'b01;
                v.pc_write = z; push(v, 1'b1);
            end
            6'b000010: begin
                v = '0; v.pc_src = 2'b10; v.pc_write = 1'b1; push(v, 1'b0);
            end
            6'b000011: begin
                v = '0; v.pc_src = 2'b10; v.pc_write = 1'b1; v.reg_write = 1'b1;
                v.reg_dst = 2'b10; v.mem_to_reg = 2'b10; push(v, 1'b1);
            end
            default: push_err();
        endcase
    endtask

    // Entered and left at posedge+1; one queue entry per clock cycle
    task automatic run_seq();
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front();
            cur_exp   = exp_q.pop_front();
            cmp_en    = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        cmp_en = 1'b0;
    endtask

    task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int fw, input int mw);
        opcode = op; funct = fn; zero = z; cur_name = nm;
        build(op, fn, z, fw, mw);
        run_seq();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_outputs_zero", 32'(act), 32'd0);
        @(negedge clk);
        chk("rst_hold_zero", 32'(act), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_release_fetch_mem_read", 32'(mem_read), 32'd1);
        chk("rst_release_err", 32'(err), 32'd0);
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
    } instr_t;

    instr_t tbl[9] = '{
        '{6'b000000, 6'b100000, 1'b0}, '{6'b000000, 6'b100010, 1'b0},
        '{6'b000000, 6'b100100, 1'b1}, '{6'b000000, 6'b100101, 1'b0},
        '{6'b000000, 6'b101010, 1'b0}, '{6'b001000, 6'b000000, 1'b0},
        '{6'b001010, 6'b111111, 1'b1}, '{6'b000010, 6'b000000, 1'b0},
        '{6'b000000, 6'b001000, 1'b0}
    };

    initial begin
        #2;
        do_reset();

        run_instr("lw", 6'b100011, 6'd0, 1'b0, 0, 0);
        chk("lw_reg_write_cycle5", 32'(rw_hist[4:0]), 32'(5'b00001));

        run_instr("beq_taken", 6'b000100, 6'd0, 1'b1, 0, 0);
        chk("beq_taken_pc_write", 32'(pw_hist[2:0]), 32'(3'b101));
        run_instr("beq_not_taken", 6'b000100, 6'd0, 1'b0, 0, 0);
        chk("beq_not_taken_pc_write", 32'(pw_hist[2:0]), 32'(3'b100));

        run_instr("jal", 6'b000011, 6'd0, 1'b0, 0, 0);
        chk("jal_reg_write", 32'(rw_hist[2:0]), 32'(3'b001));
        chk("jal_pc_write", 32'(pw_hist[2:0]), 32'(3'b101));

        for (int i = 0; i < 9; i++) run_instr("table", tbl[i].op, tbl[i].fn, tbl[i].z, 0, 0);

        run_instr("lw_waits", 6'b100011, 6'd0, 1'b0, 2, 3);

        run_instr("sw_wait5", 6'b101011, 6'd0, 1'b0, 0, 5);
        chk("sw_wait5_mem_write_len", 32'(mw_hist[8:0]), 32'(9'b000111111));
        chk("sw_wait5_err", 32'(err), 32'd0);
        run_instr("sw_wait15", 6'b101011, 6'd0, 1'b0, 0, 15);
        chk("sw_wait15_err", 32'(err), 32'd0);
        run_instr("sw_wait16", 6'b101011, 6'd0, 1'b0, 0, 16);
        chk("sw_timeout_err", 32'(err), 32'd1);
        do_reset();

        run_instr("lw_rd_timeout", 6'b100011, 6'd0, 1'b0, 1, 16);
        do_reset();
        run_instr("fetch_timeout", 6'b001000, 6'd0, 1'b0, 16, 0);
        do_reset();

        run_instr("illegal_opcode", 6'b111111, 6'd0, 1'b0, 0, 0);
        chk("illegal_opcode_err", 32'(err), 32'd1);
        chk("illegal_opcode_no_reg_write", 32'(rw_hist[4:0]), 32'd0);
        do_reset();
        run_instr("illegal_funct", 6'b000000, 6'b000111, 1'b0, 0, 0);
        chk("illegal_funct_err", 32'(err), 32'd1);
        chk("illegal_funct_no_reg_write", 32'(rw_hist[4:0]), 32'd0);
        do_reset();

        // Reset asserted in the middle of R_WB
        opcode = 6'b000000; funct = 6'b100000; zero = 1'b0; cur_name = "add_to_rwb";
        build(6'b000000, 6'b100000, 1'b0, 0, 0);
        void'(exp_q.pop_back());
        void'(rdy_q.pop_back());
        run_seq();
        mem_ready = 1'b1;
        #1;
        chk("r_wb_reg_write", 32'(reg_write), 32'd1);
        do_reset();
        chk("after_rst_no_reg_write", 32'(reg_write), 32'd0);

        run_instr("addi_after_rst", 6'b001000, 6'd0, 1'b0, 0, 0);
        run_instr("slti_after_rst", 6'b001010, 6'd0, 1'b0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
